// File: rtl/me_pkg.sv
// me_pkg: shared state encoding, REF window sizes and byte-lane constants for the frame loader
package me_pkg;

    typedef enum logic [2:0] {IDLE, LOAD_CUR, LOAD_REF, GO, WAIT_CTRL} state_t;

    localparam int CUR_WORDS_DEF = 32;
    localparam int LANE_W        = 8;
    localparam int LANES         = 8;
    localparam int REF_WORDS [4] = '{64, 128, 192, 256};

endpackage

// File: rtl/me_byte_packer.sv
// me_byte_packer: assembles 8 consecutive bytes into a 64-bit word, byte 0 in the low lane
module me_byte_packer
    import me_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LANE_W-1:0]        in_byte,
    input  logic                     valid,
    input  logic                     clear,
    output logic [LANE_W*LANES-1:0]  word,
    output logic                     word_valid
);

    logic [2:0] cnt;

    // Shift bytes in from the top so the first byte ends up in [7:0]; the full word is stable the cycle word_valid is high
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= valid && cnt == 3'd7;
            if (valid) begin
                word <= {in_byte, word[LANE_W*LANES-1:LANE_W]};
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/me_frame_loader.sv
// me_frame_loader: packs a host byte stream into CUR then REF memories and pulses go to the fetch controller.
// Optional feature macro ME_LOADER_CHECKSUM_EN adds a 16-bit byte checksum output.
module me_frame_loader
    import me_pkg::*;
#(
    parameter int CUR_ADDR_W = 8,
    parameter int REF_ADDR_W = 8,
    parameter int CUR_WORDS  = CUR_WORDS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [1:0]            r,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [7:0]            s_data,
    input  logic                  s_last,
    input  logic                  ctrl_busy,
    output logic                  cur_we,
    output logic [CUR_ADDR_W-1:0] cur_waddr,
    output logic [63:0]           cur_wdata,
    output logic                  ref_we,
    output logic [REF_ADDR_W-1:0] ref_waddr,
    output logic [63:0]           ref_wdata,
    output logic                  go,
    output logic                  busy,
    output logic                  err_len
`ifdef ME_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]           checksum
`endif
);

    localparam int BI_W = $clog2((CUR_WORDS + 256) * LANES + 1);

    state_t                state, next;
    logic [1:0]            r_q;
    logic [CUR_ADDR_W-1:0] cur_addr;
    logic [REF_ADDR_W:0]   ref_addr;
    logic [BI_W-1:0]       byte_idx;
    logic                  done, seen;
    logic [63:0]           pk_word;
    logic                  pk_valid;
    logic                  accept, start, final_byte, abort, last_cur, last_ref;

    // The byte index spans the whole load so s_last is judged independently of which memory the FSM is steering to
    assign accept     = s_valid && s_ready;
    assign start      = state == IDLE && load_start && !ctrl_busy;
    assign final_byte = int'(byte_idx) == (CUR_WORDS + REF_WORDS[r_q]) * LANES - 1;
    assign abort      = accept && (s_last != final_byte);
    assign last_cur   = int'(cur_addr) == CUR_WORDS - 1;
    assign last_ref   = int'(ref_addr) == REF_WORDS[r_q] - 1;

    me_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .in_byte    (s_data),
        .valid      (accept),
        .clear      (abort || state == IDLE),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    // Next-state logic; a length error abandons the load from either load state
    always_comb begin
        next = state;
        case (state)
            IDLE:      next = start ? LOAD_CUR : IDLE;
            LOAD_CUR:  next = abort ? IDLE : (cur_we && last_cur) ? LOAD_REF : LOAD_CUR;
            LOAD_REF:  next = abort ? IDLE : (ref_we && last_ref) ? GO : LOAD_REF;
            GO:        next = WAIT_CTRL;
            WAIT_CTRL: next = (seen && !ctrl_busy) ? IDLE : WAIT_CTRL;
            default:   next = IDLE;
        endcase
    end

    // Outputs; a finished packer word goes to whichever memory the current state owns
    always_comb begin
        s_ready   = (state == LOAD_CUR || state == LOAD_REF) && !done;
        cur_we    = pk_valid && state == LOAD_CUR;
        ref_we    = pk_valid && state == LOAD_REF;
        cur_waddr = cur_addr;
        ref_waddr = ref_addr[REF_ADDR_W-1:0];
        cur_wdata = pk_word;
        ref_wdata = pk_word;
        go        = state == GO;
        busy      = state != IDLE;
    end

    // Load bookkeeping: range latch, post-increment addresses, byte position, sticky length error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q      <= '0;
            cur_addr <= '0;
            ref_addr <= '0;
            byte_idx <= '0;
            done     <= 1'b0;
            err_len  <= 1'b0;
        end else if (start) begin
            r_q      <= r;
            cur_addr <= '0;
            ref_addr <= '0;
            byte_idx <= '0;
            done     <= 1'b0;
            err_len  <= 1'b0;
        end else begin
            if (accept) byte_idx <= byte_idx + 1'b1;
            if (accept && final_byte) done <= 1'b1;
            if (abort) err_len <= 1'b1;
            if (cur_we) cur_addr <= cur_addr + 1'b1;
            if (ref_we) ref_addr <= ref_addr + 1'b1;
        end
    end

    // Remember whether the controller has raised busy since go, so WAIT_CTRL leaves only on its falling edge
    always_ff @(posedge clk) begin
        if (reset) seen <= 1'b0;
        else       seen <= state == GO ? ctrl_busy : state == WAIT_CTRL ? (seen || ctrl_busy) : 1'b0;
    end

`ifdef ME_LOADER_CHECKSUM_EN
    // Running byte sum for the current load; naturally holds once streaming stops
    always_ff @(posedge clk) begin
        if (reset || start) checksum <= '0;
        else if (accept)    checksum <= checksum + {8'd0, s_data};
    end
`endif

endmodule

// File: tb/tb_me_frame_loader.sv
// tb_me_frame_loader: scoreboard bench for me_frame_loader (nominal, max range, errors, reset, interlock)
module tb_me_frame_loader;

    logic        clk = 1'b0;
    logic        reset, load_start, s_valid, s_ready, s_last, ctrl_busy;
    logic [1:0]  r;
    logic [7:0]  s_data, cur_waddr, ref_waddr;
    logic [63:0] cur_wdata, ref_wdata;
    logic        cur_we, ref_we, go, busy, err_len;
`ifdef ME_LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    me_frame_loader dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .r          (r),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .ctrl_busy  (ctrl_busy),
        .cur_we     (cur_we),
        .cur_waddr  (cur_waddr),
        .cur_wdata  (cur_wdata),
        .ref_we     (ref_we),
        .ref_waddr  (ref_waddr),
        .ref_wdata  (ref_wdata),
        .go         (go),
        .busy       (busy),
        .err_len    (err_len)
`ifdef ME_LOADER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [71:0] cur_q[$], ref_q[$];
    logic [71:0] e;
    logic [63:0] acc, first_cur;
    logic [15:0] sum;
    logic [7:0]  last_ref_addr;
    int nb, nw, cyc = 0, prev_we = -1, last_cur = 0, go_cnt = 0, ref_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: pops the scoreboard and checks the 8-clock cadence
    always @(negedge clk) begin
        if (cur_we) begin
            if (cur_q.size() == 0) check("cur_unexpected", 80'(cur_waddr), 80'hFFFF);
            else begin
                e = cur_q.pop_front();
                check("cur_wr", 80'({cur_waddr, cur_wdata}), 80'(e));
            end
            if (cur_waddr == 8'd0) first_cur = cur_wdata;
            if (prev_we >= 0) check("cur_gap", 80'(cyc - prev_we), 80'd8);
            prev_we  = cyc;
            last_cur = cyc;
        end
        if (ref_we) begin
            if (ref_q.size() == 0) check("ref_unexpected", 80'(ref_waddr), 80'hFFFF);
            else begin
                e = ref_q.pop_front();
                check("ref_wr", 80'({ref_waddr, ref_wdata}), 80'(e));
            end
            if (ref_cnt == 0) check("cur2ref", 80'(cyc - last_cur), 80'd8);
            else if (prev_we >= 0) check("ref_gap", 80'(cyc - prev_we), 80'd8);
            prev_we       = cyc;
            ref_cnt       = ref_cnt + 1;
            last_ref_addr = ref_waddr;
        end
        if (go) go_cnt = go_cnt + 1;
    end

    task automatic start_load(input logic [1:0] rr);
        r = rr;
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        nb = 0; nw = 0; acc = '0; sum = '0;
        prev_we = -1; ref_cnt = 0; go_cnt = 0;
    endtask

    // Drive n bytes (value = index mod 256), s_last on index last_at; model words as bytes are accepted
    task automatic send(input int n, input int last_at);
        int t;
        for (int i = 0; i < n; i++) begin
            s_data  = 8'(i);
            s_last  = (i == last_at);
            s_valid = 1'b1;
            @(negedge clk);
            t = 0;
            while (!s_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!s_ready) begin
                check("s_ready_timeout", 80'(i), 80'hFFFF);
                break;
            end
            acc = {s_data, acc[63:8]};
            sum = sum + {8'd0, s_data};
            nb++;
            if (nb == 8) begin
                nb = 0;
                if (nw < 32) cur_q.push_back({8'(nw), acc});
                else         ref_q.push_back({8'(nw - 32), acc});
                nw++;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Wait for go, then exercise the WAIT_CTRL handshake with the controller
    task automatic finish_ctrl(input string tag);
        int t = 0;
        while (go_cnt == 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_go_seen"}, 80'(go_cnt > 0), 80'd1);
        repeat (3) @(negedge clk);
        check({tag, "_wait_busy"}, 80'(busy), 80'd1);
        @(posedge clk); #1;
        ctrl_busy = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check({tag, "_ctrl_busy_hold"}, 80'(busy), 80'd1);
        @(posedge clk); #1;
        ctrl_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_idle_after_ctrl"}, 80'(busy), 80'd0);
        check({tag, "_go_once"}, 80'(go_cnt), 80'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; load_start = 1'b0; r = '0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; ctrl_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 80'(busy), 80'd0);
        check("rst_ready", 80'(s_ready), 80'd0);
        check("rst_go", 80'(go), 80'd0);
        check("rst_err", 80'(err_len), 80'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // load_start while the controller is busy must be ignored
        ctrl_busy = 1'b1; load_start = 1'b1;
        repeat (2) @(posedge clk); #1;
        load_start = 1'b0;
        @(negedge clk);
        check("ignored_busy", 80'(busy), 80'd0);
        check("ignored_ready", 80'(s_ready), 80'd0);
        @(posedge clk); #1;
        ctrl_busy = 1'b0;

        // Nominal r=0: 32 CUR + 64 REF words
        start_load(2'd0);
        send(768, 767);
        repeat (3) @(negedge clk);
        check("nom_cur_left", 80'(cur_q.size()), 80'd0);
        check("nom_ref_left", 80'(ref_q.size()), 80'd0);
        check("nom_ref_cnt", 80'(ref_cnt), 80'd64);
        check("nom_cur0", 80'(first_cur), 80'h0706050403020100);
        check("nom_err", 80'(err_len), 80'd0);
`ifdef ME_LOADER_CHECKSUM_EN
        check("nom_csum", 80'(checksum), 80'(sum));
`endif
        finish_ctrl("nom");

        // Max range r=3: 256 REF words, top address 255 without wrap
        start_load(2'd3);
        send(2304, 2303);
        repeat (3) @(negedge clk);
        check("max_ref_cnt", 80'(ref_cnt), 80'd256);
        check("max_last_addr", 80'(last_ref_addr), 80'd255);
        check("max_ref_left", 80'(ref_q.size()), 80'd0);
        finish_ctrl("max");

        // Early s_last on the 100th byte aborts the load
        start_load(2'd1);
        send(100, 99);
        repeat (3) @(negedge clk);
        check("early_err", 80'(err_len), 80'd1);
        check("early_busy", 80'(busy), 80'd0);
        check("early_nogo", 80'(go_cnt), 80'd0);
        check("early_cur_left", 80'(cur_q.size()), 80'd0);
        @(posedge clk); #1;

        // Next accepted load_start clears err_len; then reset mid-LOAD_REF
        start_load(2'd0);
        @(negedge clk);
        check("err_cleared", 80'(err_len), 80'd0);
        @(posedge clk); #1;
        send(400, -1);
        repeat (2) @(posedge clk); #1;
        check("rst_mid_busy_before", 80'(busy), 80'd1);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rstm_busy", 80'(busy), 80'd0);
        check("rstm_outs", 80'({cur_we, ref_we, go, err_len, s_ready}), 80'd0);
        check("rstm_addr", 80'({cur_waddr, ref_waddr}), 80'd0);
        check("rstm_data", 80'(cur_wdata | ref_wdata), 80'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("rstm_nogo", 80'(go_cnt), 80'd0);
        check("rstm_idle", 80'(busy), 80'd0);
        check("rstm_ref_left", 80'(ref_q.size()), 80'd0);
        @(posedge clk); #1;

        // Missing s_last on the final byte: error, final word dropped, no go
        start_load(2'd0);
        send(768, -1);
        repeat (3) @(negedge clk);
        check("late_err", 80'(err_len), 80'd1);
        check("late_nogo", 80'(go_cnt), 80'd0);
        check("late_busy", 80'(busy), 80'd0);
        check("late_dropped", 80'(ref_q.size()), 80'd1);
        ref_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
